// File: rtl/drive_cmd_uart_tx.sv
// Drive command UART transmitter: encodes W/A/S/D key state into a command byte
// and sends it 8N1 (LSB first) on every change and on a keepalive timer.
module drive_cmd_uart_tx #(
  parameter int CLK_FREQ_HZ      = 50_000_000,
  parameter int BAUD             = 115200,
  parameter int KEEPALIVE_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       key_w,
  input  logic       key_a,
  input  logic       key_s,
  input  logic       key_d,
  output logic       tx,
  output logic       tx_busy,
  output logic [7:0] cmd_sent,
  output logic       sent_pulse
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int KA_W   = (KEEPALIVE_CYCLES > 1) ? $clog2(KEEPALIVE_CYCLES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [KA_W-1:0]   KA_LAST   = KA_W'(KEEPALIVE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        key_meta_q, key_sync_q;  // {d, s, a, w}
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [KA_W-1:0]   ka_cnt_q, ka_cnt_d;
  logic              ka_pend_q, ka_pend_d;
  logic              launch;
  logic              w_c, a_c, s_c, d_c;
  logic [7:0]        encoded;

  // Opposing keys cancel each other out rather than one taking priority.
  always_comb begin
    w_c     = key_sync_q[0] & ~key_sync_q[2];
    s_c     = key_sync_q[2] & ~key_sync_q[0];
    a_c     = key_sync_q[1] & ~key_sync_q[3];
    d_c     = key_sync_q[3] & ~key_sync_q[1];
    encoded = enable ? {4'b0000, d_c, s_c, a_c, w_c} : 8'h00;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    cmd_d   = cmd_q;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if ((encoded != cmd_q) || ka_pend_q) begin
          launch  = 1'b1;
          shift_d = encoded;
          cmd_d   = encoded;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          baud_d  = BAUD_LAST;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          tx_d    = shift_q[0];
          baud_d  = BAUD_LAST;
          state_d = DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LAST;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter saturates once expired; the pending flag holds until the next launch.
    ka_cnt_d  = launch ? '0 : ((ka_cnt_q == KA_LAST) ? ka_cnt_q : ka_cnt_q + 1'b1);
    ka_pend_d = launch ? 1'b0 : (ka_pend_q | (ka_cnt_q == KA_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_meta_q <= '0;
      key_sync_q <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      cmd_q      <= 8'h00;
      ka_cnt_q   <= '0;
      ka_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_meta_q <= {key_d, key_s, key_a, key_w};
      key_sync_q <= key_meta_q;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      cmd_q      <= cmd_d;
      ka_cnt_q   <= ka_cnt_d;
      ka_pend_q  <= ka_pend_d;
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign cmd_sent   = cmd_q;
  assign sent_pulse = (state_q == STOP) && (baud_q == '0);

endmodule

// File: tb/tb_drive_cmd_uart_tx.sv
// Bench for drive_cmd_uart_tx: a line monitor decodes every UART frame and
// compares it against bytes queued by the directed stimulus.
module tb_drive_cmd_uart_tx;
  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       key_w = 1'b0, key_a = 1'b0, key_s = 1'b0, key_d = 1'b0;
  logic       tx, tx_busy, sent_pulse;
  logic [7:0] cmd_sent;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int   frames_seen = 0;
  int   pulses = 0;
  int   start_cyc = 0;
  int   pulse_cyc = -1000;
  int   last_gap = 0;
  int   busy_run = 0;
  int   last_busy_run = 0;
  bit   mon_active = 1'b0;
  int   mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] mon_exp = 8'h00;

  drive_cmd_uart_tx #(
    .CLK_FREQ_HZ(1000),
    .BAUD(100),
    .KEEPALIVE_CYCLES(500)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .key_w(key_w),
    .key_a(key_a),
    .key_s(key_s),
    .key_d(key_d),
    .tx(tx),
    .tx_busy(tx_busy),
    .cmd_sent(cmd_sent),
    .sent_pulse(sent_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Line monitor: frame cycle 0 is the first cycle tx is seen low.
  always @(negedge clk) begin
    if (sent_pulse === 1'b1) begin
      pulses++;
      pulse_cyc = cyc;
    end
    if (tx_busy === 1'b1) busy_run++;
    else if (busy_run != 0) begin
      last_busy_run = busy_run;
      busy_run = 0;
    end
    if (rst_n !== 1'b1) begin
      mon_active = 1'b0;
      busy_run = 0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt = 0;
        mon_byte = 8'h00;
        start_cyc = cyc;
        last_gap = cyc - pulse_cyc;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == CPB / 2) check("start_bit", {31'b0, tx}, 32'd0);
      else if (mon_cnt > CPB && mon_cnt < 9 * CPB && (mon_cnt % CPB) == CPB / 2)
        mon_byte[(mon_cnt / CPB) - 1] = tx;
      else if (mon_cnt == 9 * CPB + CPB / 2) check("stop_bit", {31'b0, tx}, 32'd1);
      if (mon_cnt == FRAME - 1) check("sent_pulse_last_stop", {31'b0, sent_pulse}, 32'd1);
      if (mon_cnt == FRAME) begin
        check("idle_after_frame", {30'b0, tx_busy, tx}, 32'd1);
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_frame: observed=0x%0h expected=none", mon_byte);
        end
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("frame_byte", {24'b0, mon_byte}, {24'b0, mon_exp});
          check("cmd_sent", {24'b0, cmd_sent}, {24'b0, mon_exp});
        end
        frames_seen++;
        mon_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_keys(input logic [3:0] k);
    {key_d, key_s, key_a, key_w} = k;
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n = 0;
    while (frames_seen < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (frames_seen >= target) else begin
      errors++;
      $error("FAIL %s: timeout observed=%0d frames expected=%0d", tag, frames_seen, target);
    end
  endtask

  task automatic wait_tx_low(input int budget, input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (tx === 1'b0) else begin
      errors++;
      $error("FAIL %s: timeout observed tx=%b expected=0", tag, tx);
    end
  endtask

  logic [3:0] pat_keys[5] = '{4'b0011, 4'b1100, 4'b0110, 4'b1101, 4'b0000};
  logic [7:0] pat_byte[5] = '{8'h03, 8'h0C, 8'h06, 8'h08, 8'h00};

  initial begin
    int t0;
    int nf;
    enable = 1'b1;
    set_keys(4'b0000);
    repeat (3) tick();
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, tx_busy}, 32'd0);
    check("rst_cmd_sent", {24'b0, cmd_sent}, 32'h00);
    check("rst_sent_pulse", {31'b0, sent_pulse}, 32'd0);

    // Keepalive frame of 0x00 after reset
    rst_n = 1'b1;
    t0 = cyc;
    exp_q.push_back(8'h00);
    nf = frames_seen + 1;
    wait_frames(nf, 700, "keepalive_frame");
    check_range("keepalive_start_delay", start_cyc - t0, 495, 505);
    check("keepalive_pulses", pulses, 32'd1);
    check("keepalive_busy_len", last_busy_run, FRAME);

    // Forward key
    tick();
    t0 = cyc;
    set_keys(4'b0001);
    exp_q.push_back(8'h01);
    nf = frames_seen + 1;
    wait_frames(nf, 300, "fwd_frame");
    check_range("fwd_start_latency", start_cyc - t0, 1, 4);
    check("fwd_busy_len", last_busy_run, FRAME);

    // Key combinations including cancellation
    for (int i = 0; i < 5; i++) begin
      tick();
      set_keys(pat_keys[i]);
      exp_q.push_back(pat_byte[i]);
      nf = frames_seen + 1;
      wait_frames(nf, 300, "combo_frame");
      check("combo_busy_len", last_busy_run, FRAME);
    end

    // a+d cancels to Stop, which matches the last sent byte
    nf = frames_seen;
    set_keys(4'b1010);
    repeat (60) begin
      tick();
      if (tx_busy !== 1'b0) break;
    end
    check("ad_no_busy", {31'b0, tx_busy}, 32'd0);
    check("ad_no_frame", frames_seen, nf);

    // Key change mid-frame: current frame intact, then latest value
    set_keys(4'b0001);
    exp_q.push_back(8'h01);
    nf = frames_seen + 2;
    wait_tx_low(20, "midframe_start");
    while (cyc - start_cyc < 30) tick();
    set_keys(4'b1000);
    exp_q.push_back(8'h08);
    wait_frames(nf, 400, "midframe_frames");
    check("midframe_gap", last_gap, 32'd2);

    // Enable gating with key_w held
    set_keys(4'b0001);
    exp_q.push_back(8'h01);
    nf = frames_seen + 1;
    wait_frames(nf, 300, "en_fwd_frame");
    tick();
    enable = 1'b0;
    exp_q.push_back(8'h00);
    nf = frames_seen + 1;
    wait_frames(nf, 300, "en_off_frame");
    tick();
    enable = 1'b1;
    exp_q.push_back(8'h01);
    nf = frames_seen + 1;
    wait_frames(nf, 300, "en_on_frame");

    // Reset during data bit 4 of a 0x00 frame
    tick();
    set_keys(4'b0000);
    wait_tx_low(20, "abort_start");
    while (cyc - start_cyc < 55) tick();
    check("abort_pre_tx", {31'b0, tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_tx", {31'b0, tx}, 32'd1);
    check("abort_busy", {31'b0, tx_busy}, 32'd0);
    repeat (3) tick();
    check("abort_cmd_sent", {24'b0, cmd_sent}, 32'h00);
    rst_n = 1'b1;
    t0 = cyc;
    exp_q.push_back(8'h00);
    nf = frames_seen + 1;
    wait_frames(nf, 700, "post_abort_frame");
    check_range("post_abort_delay", start_cyc - t0, 495, 505);
    repeat (5) tick();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
